// File: rtl/nios_btn_led_pio_pkg.sv
// Shared definitions for the Nios button/LED peripheral: register word addresses
// and edge-capture type encodings.
package nios_btn_led_pio_pkg;

  localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd1;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd2;
  localparam logic [2:0] ADDR_LED_DATA = 3'd3;
  localparam logic [2:0] ADDR_LED_MODE = 3'd4;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_type_e;

endpackage

// File: rtl/nios_btn_led_pio_btn_debounce.sv
// One button channel: 2-FF synchroniser with optional inversion, stability counter,
// debounced level and a one-cycle pulse on qualifying transitions of that level.
module btn_debounce
  import nios_btn_led_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 120000,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int EDGE_TYPE    = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic stable,
  output logic edge_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = (sync != stable) && (cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      meta <= ACTIVE_LOW ? ~pin : pin;
      sync <= meta;
      if (sync == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // The pulse coincides with the edge on which stable takes the new value.
  if (EDGE_TYPE == int'(EDGE_RISE)) begin : g_rise
    assign edge_pulse = accept & sync;
  end else if (EDGE_TYPE == int'(EDGE_FALL)) begin : g_fall
    assign edge_pulse = accept & ~sync;
  end else begin : g_both
    assign edge_pulse = accept;
  end

endmodule

// File: rtl/nios_btn_led_pio.sv
// Avalon-MM button/LED peripheral: debounced button inputs with maskable edge IRQ,
// and LEDs with per-bit direct or blink drive.
module nios_btn_led_pio
  import nios_btn_led_pio_pkg::*;
#(
  parameter int N_BTN          = 1,
  parameter int N_LED          = 8,
  parameter int BTN_ACTIVE_LOW = 1,
  parameter int DEBOUNCE_CYC   = 120000,
  parameter int BLINK_HALF_CYC = 3000000,
  parameter int EDGE_TYPE      = 0
) (
  input  logic             CLK12M,
  input  logic             RST_BTN,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_LED-1:0] led_out
);

  if (N_BTN < 1 || N_BTN > 32) begin : g_bad_n_btn
    $error("N_BTN must be in 1..32");
  end
  if (N_LED < 1 || N_LED > 32) begin : g_bad_n_led
    $error("N_LED must be in 1..32");
  end
  if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYC must be >= 2");
  end
  if (BLINK_HALF_CYC < 2) begin : g_bad_blink
    $error("BLINK_HALF_CYC must be >= 2");
  end

  localparam int PW = $clog2(BLINK_HALF_CYC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(BLINK_HALF_CYC - 1);

  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] edge_set;
  logic [N_BTN-1:0] irq_mask;
  logic [N_BTN-1:0] edge_cap;
  logic [N_BTN-1:0] cap_clr;
  logic [N_LED-1:0] led_data;
  logic [N_LED-1:0] led_mode;
  logic [PW-1:0]    presc;
  logic             blink_phase;
  logic [31:0]      rd_value;
  logic             wd_unused;

  assign wd_unused = ^avs_writedata;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .ACTIVE_LOW   (BTN_ACTIVE_LOW != 0),
      .EDGE_TYPE    (EDGE_TYPE)
    ) u_debounce (
      .clk        (CLK12M),
      .rst        (RST_BTN),
      .pin        (btn_in[i]),
      .stable     (stable[i]),
      .edge_pulse (edge_set[i])
    );
  end

  assign cap_clr = (avs_write && avs_address == ADDR_EDGE_CAP) ?
                   avs_writedata[N_BTN-1:0] : '0;

  // NOTE: rd_value gets a default before the case so no path leaves it unassigned
  // (otherwise a latch is inferred).
  always_comb begin
    rd_value = '0;
    case (avs_address)
      ADDR_DATA_IN:  rd_value[N_BTN-1:0] = stable;
      ADDR_IRQ_MASK: rd_value[N_BTN-1:0] = irq_mask;
      ADDR_EDGE_CAP: rd_value[N_BTN-1:0] = edge_cap;
      ADDR_LED_DATA: rd_value[N_LED-1:0] = led_data;
      ADDR_LED_MODE: rd_value[N_LED-1:0] = led_mode;
      default:       rd_value = '0;
    endcase
  end

  // Register file and bus read; a same-cycle read sees the pre-write contents.
  always_ff @(posedge CLK12M or posedge RST_BTN) begin
    if (RST_BTN) begin
      irq_mask     <= '0;
      edge_cap     <= '0;
      led_data     <= '0;
      led_mode     <= '0;
      avs_readdata <= '0;
    end else begin
      avs_readdata <= avs_read ? rd_value : '0;
      edge_cap     <= (edge_cap & ~cap_clr) | edge_set;
      if (avs_write) begin
        case (avs_address)
          ADDR_IRQ_MASK: irq_mask <= avs_writedata[N_BTN-1:0];
          ADDR_LED_DATA: led_data <= avs_writedata[N_LED-1:0];
          ADDR_LED_MODE: led_mode <= avs_writedata[N_LED-1:0];
          default: ;
        endcase
      end
    end
  end

  // Free-running blink prescaler; LED_MODE writes do not disturb it.
  always_ff @(posedge CLK12M or posedge RST_BTN) begin
    if (RST_BTN) begin
      presc       <= '0;
      blink_phase <= 1'b0;
    end else if (presc == PRESC_LAST) begin
      presc       <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge CLK12M or posedge RST_BTN) begin
    if (RST_BTN) begin
      irq     <= 1'b0;
      led_out <= '0;
    end else begin
      irq     <= |(edge_cap & irq_mask);
      led_out <= (led_data & ~led_mode) | (led_data & led_mode & {N_LED{blink_phase}});
    end
  end

endmodule

// File: tb/tb_nios_btn_led_pio.sv
// Self-checking bench: windowed behavioural model of the peripheral, per-cycle
// compare on negedge, directed literal checks plus randomized bus/button traffic.
module tb_nios_btn_led_pio;

  localparam int D  = 4;
  localparam int H  = 5;
  localparam int NB = 2;
  localparam int NL = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   readdata;
  logic          irq;
  logic [NB-1:0] btn_in = '1;
  logic [NL-1:0] led_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nios_btn_led_pio #(
    .N_BTN          (NB),
    .N_LED          (NL),
    .BTN_ACTIVE_LOW (1),
    .DEBOUNCE_CYC   (D),
    .BLINK_HALF_CYC (H),
    .EDGE_TYPE      (0)
  ) dut (
    .CLK12M        (clk),
    .RST_BTN       (rst),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (readdata),
    .irq           (irq),
    .btn_in        (btn_in),
    .led_out       (led_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Debounced level flips once the synchronised pressed-level has disagreed with it
  // for D consecutive edges; synchronised value at an edge = pressed-level 2 edges earlier.
  logic [NB-1:0] hist [0:D+1];
  logic [NB-1:0] m_stable, m_cap, m_mask;
  logic [NL-1:0] m_data, m_mode, m_led;
  logic          m_irq;
  logic [31:0]   m_rd;
  logic          m_rd_valid;
  int            n_edge;

  function automatic logic [31:0] model_reg(input logic [2:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      3'd0: v[NB-1:0] = m_stable;
      3'd1: v[NB-1:0] = m_mask;
      3'd2: v[NB-1:0] = m_cap;
      3'd3: v[NL-1:0] = m_data;
      3'd4: v[NL-1:0] = m_mode;
      default: v = '0;
    endcase
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [NB-1:0] nx_hist [0:D+1];
    logic [NB-1:0] nx_stable, set_bits, clr_bits;
    bit            all_diff;
    logic          phase;
    if (rst) begin
      m_stable   <= '0;
      m_cap      <= '0;
      m_mask     <= '0;
      m_data     <= '0;
      m_mode     <= '0;
      m_led      <= '0;
      m_irq      <= 1'b0;
      m_rd       <= '0;
      m_rd_valid <= 1'b0;
      n_edge     <= 0;
      for (int j = 0; j <= D + 1; j++) hist[j] <= '0;
    end else begin
      nx_hist[0] = ~btn_in;
      for (int j = 1; j <= D + 1; j++) nx_hist[j] = hist[j-1];
      nx_stable = m_stable;
      set_bits  = '0;
      for (int c = 0; c < NB; c++) begin
        all_diff = 1'b1;
        for (int j = 2; j <= D + 1; j++)
          if (nx_hist[j][c] == m_stable[c]) all_diff = 1'b0;
        if (all_diff) begin
          nx_stable[c] = ~m_stable[c];
          if (nx_stable[c]) set_bits[c] = 1'b1;
        end
      end
      clr_bits = (avs_write && avs_address == 3'd2) ? avs_writedata[NB-1:0] : '0;
      phase    = ((n_edge / H) % 2) == 1;
      m_rd_valid <= avs_read;
      m_rd       <= avs_read ? model_reg(avs_address) : 32'h0;
      m_irq      <= |(m_cap & m_mask);
      for (int i = 0; i < NL; i++)
        m_led[i] <= m_mode[i] ? (m_data[i] & phase) : m_data[i];
      m_cap    <= (m_cap & ~clr_bits) | set_bits;
      m_stable <= nx_stable;
      for (int j = 0; j <= D + 1; j++) hist[j] <= nx_hist[j];
      if (avs_write) begin
        case (avs_address)
          3'd1: m_mask <= avs_writedata[NB-1:0];
          3'd3: m_data <= avs_writedata[NL-1:0];
          3'd4: m_mode <= avs_writedata[NL-1:0];
          default: ;
        endcase
      end
      n_edge <= n_edge + 1;
    end
  end

  always @(negedge clk) begin
    check("led_out", 32'(led_out), 32'(m_led));
    check("irq", 32'(irq), 32'(m_irq));
    if (m_rd_valid) check("readdata", readdata, m_rd);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    step();
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    step();
    avs_read = 1'b0;
    d = readdata;
  endtask

  // Reads DATA_IN on the 7 edges after a pin change; only the 7th sees the new level.
  task automatic check_latency(input string tag, input logic [31:0] final_val,
                               input logic [31:0] prior_val);
    logic [31:0] d;
    for (int k = 1; k <= 7; k++) begin
      bus_read(3'd0, d);
      if (k == 6) check({tag, "_k6"}, d, prior_val);
      if (k == 7) check({tag, "_k7"}, d, final_val);
    end
  endtask

  initial begin
    logic [31:0] d;

    steps(3);
    rst = 1'b0;
    step();

    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d);
      check($sformatf("reset_reg%0d", a), d, 32'h0);
    end
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_led", 32'(led_out), 32'h0);

    btn_in[0] = 1'b0;
    check_latency("press0", 32'h1, 32'h0);
    bus_read(3'd2, d);
    check("edgecap_after_press", d, 32'h1);
    check("irq_masked", 32'(irq), 32'h0);
    bus_write(3'd1, 32'h1);
    check("irq_not_yet", 32'(irq), 32'h0);
    step();
    check("irq_after_mask", 32'(irq), 32'h1);

    btn_in[1] = 1'b0;
    steps(3);
    btn_in[1] = 1'b1;
    steps(10);
    bus_read(3'd0, d);
    check("glitch_datain", d, 32'h1);
    bus_read(3'd2, d);
    check("glitch_edgecap", d, 32'h1);

    btn_in[0] = 1'b1;
    steps(10);
    btn_in[0] = 1'b0;
    steps(5);
    bus_write(3'd2, 32'h1);
    check("set_w1c_irq", 32'(irq), 32'h1);
    bus_read(3'd2, d);
    check("set_w1c_cap", d, 32'h1);
    steps(2);
    check("set_w1c_irq_hold", 32'(irq), 32'h1);
    bus_write(3'd2, 32'h1);
    check("w1c_irq_lag", 32'(irq), 32'h1);
    step();
    check("w1c_irq_drop", 32'(irq), 32'h0);
    bus_read(3'd2, d);
    check("w1c_cap", d, 32'h0);

    bus_write(3'd3, 32'hA5);
    bus_write(3'd4, 32'h0F);
    steps(2);
    for (int i = 0; i < 20; i++) begin
      step();
      check("led_hi", 32'(led_out[7:4]), 32'hA);
      check("led_lo_set", 32'(led_out[3:0] == 4'h5 || led_out[3:0] == 4'h0), 32'h1);
    end

    btn_in[0] = 1'b1;
    steps(10);
    btn_in[0] = 1'b0;
    steps(4);
    rst = 1'b1;
    #1;
    check("rst_led", 32'(led_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rdata", readdata, 32'h0);
    steps(2);
    rst = 1'b0;
    check_latency("requal", 32'h1, 32'h0);
    bus_read(3'd2, d);
    check("requal_cap", d, 32'h1);

    for (int cyc = 0; cyc < 800; cyc++) begin
      if ($urandom_range(0, 7) == 0) btn_in[$urandom_range(0, NB-1)] ^= 1'b1;
      avs_address   = 3'($urandom_range(0, 7));
      avs_writedata = $urandom;
      avs_read      = ($urandom_range(0, 2) == 0);
      avs_write     = ($urandom_range(0, 3) == 0);
      if (cyc == 400) rst = 1'b1;
      if (cyc == 402) rst = 1'b0;
      step();
    end
    avs_read  = 1'b0;
    avs_write = 1'b0;
    steps(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
